// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: forwarding source codes, mult/div
// tracker state type, default latencies and the register match rule.
package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 12;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // r0 is hardwired to zero, so a write to it never produces a dependency
  function automatic logic reg_match(input logic       uses,
                                     input logic [4:0] src,
                                     input logic       we,
                                     input logic [4:0] dst);
    return uses & we & (dst == src) & (src != 5'd0);
  endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks the hi/lo busy window of the multi-cycle mult/div unit.
//   state | meaning
//   IDLE  | no mult/div in flight, a new start is accepted
//   BUSY  | md_cnt cycles of busy remain, including the current one
module md_busy_tracker
  import pipe_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic md_type,
  output logic md_busy
);

  md_state_t  state;
  logic [3:0] md_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      md_cnt  <= 4'd0;
      md_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            md_cnt  <= md_type ? 4'(DIV_LAT) : 4'(MULT_LAT);
            state   <= BUSY;
            md_busy <= 1'b1;
          end
        end
        BUSY: begin
          md_cnt <= md_cnt - 4'd1;
          if (md_cnt == 4'd1) begin
            state   <= IDLE;
            md_busy <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Pipeline hazard control: operand forwarding selects, load-use / branch /
// mult-div stalls, taken-branch flush and a saturating stall counter.
module hazard_forward_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_LAT   = MULT_LAT_DEF,
  parameter int DIV_LAT    = DIV_LAT_DEF,
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_md_start,
  input  logic             id_md_type,
  input  logic             id_hilo_read,
  input  logic             branch_taken,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memload,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_memload,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             idex_nop,
  output logic             ifid_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic match_ex_rs, match_ex_rt, match_mem_rs, match_mem_rt;
  logic match_wb_rs, match_wb_rt;
  logic load_use, br_haz, md_haz, stall;

  localparam logic FLUSH_EN = (DELAY_SLOT == 0);

  assign match_ex_rs  = reg_match(id_uses_rs, id_rs, ex_regwrite,  ex_rd);
  assign match_ex_rt  = reg_match(id_uses_rt, id_rt, ex_regwrite,  ex_rd);
  assign match_mem_rs = reg_match(id_uses_rs, id_rs, mem_regwrite, mem_rd);
  assign match_mem_rt = reg_match(id_uses_rt, id_rt, mem_regwrite, mem_rd);
  assign match_wb_rs  = reg_match(id_uses_rs, id_rs, wb_regwrite,  wb_rd);
  assign match_wb_rt  = reg_match(id_uses_rt, id_rt, wb_regwrite,  wb_rd);

  assign load_use = ex_memload & (match_ex_rs | match_ex_rt);
  // branch compares in ID, so even an ALU result in EX is too late to forward
  assign br_haz   = id_is_branch & ((match_ex_rs | match_ex_rt) |
                                    (mem_memload & (match_mem_rs | match_mem_rt)));
  assign md_haz   = md_busy & (id_hilo_read | id_md_start);
  assign stall    = ~reset & (load_use | br_haz | md_haz);

  always_comb begin
    fwd_a_sel = FWD_RF;
    fwd_b_sel = FWD_RF;
    if (!reset) begin
      if (match_ex_rs)       fwd_a_sel = FWD_EX;
      else if (match_mem_rs) fwd_a_sel = FWD_MEM;
      else if (match_wb_rs)  fwd_a_sel = FWD_WB;

      if (match_ex_rt)       fwd_b_sel = FWD_EX;
      else if (match_mem_rt) fwd_b_sel = FWD_MEM;
      else if (match_wb_rt)  fwd_b_sel = FWD_WB;
    end
  end

  assign pc_le      = ~reset & ~stall;
  assign ifid_le    = ~reset & ~stall;
  assign idex_nop   = reset | stall;
  assign ifid_flush = FLUSH_EN & ~reset & branch_taken & ~stall;

  md_busy_tracker #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_tracker (
    .clk     (clk),
    .reset   (reset),
    .start   (id_md_start & ~stall),
    .md_type (id_md_type),
    .md_busy (md_busy)
  );

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed scenarios plus random
// stimulus compared against a cycle-level behavioural model.
module tb_hazard_forward_ctrl;

  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 12;
  localparam int CNT_W    = 6;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs, id_uses_rt, id_is_branch, id_md_start, id_md_type;
  logic id_hilo_read, branch_taken, ex_regwrite, ex_memload;
  logic mem_regwrite, mem_memload, wb_regwrite;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic pc_le, ifid_le, idex_nop, ifid_flush, md_busy;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int m_busy_rem = 0;
  int m_stall_cnt = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(
    .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .DELAY_SLOT(0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_md_start(id_md_start), .id_md_type(id_md_type),
    .id_hilo_read(id_hilo_read), .branch_taken(branch_taken),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memload(ex_memload),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memload(mem_memload),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .pc_le(pc_le), .ifid_le(ifid_le),
    .idex_nop(idex_nop), .ifid_flush(ifid_flush), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit dep(input logic uses, input logic [4:0] r,
                             input logic we, input logic [4:0] rd);
    return uses && we && (rd == r) && (r != 0);
  endfunction

  // youngest producer wins: EX=1, MEM=2, WB=3, none=0
  function automatic int source_of(input logic uses, input logic [4:0] r);
    logic [4:0] rds [3];
    logic       wes [3];
    rds = '{ex_rd, mem_rd, wb_rd};
    wes = '{ex_regwrite, mem_regwrite, wb_regwrite};
    for (int i = 0; i < 3; i++)
      if (dep(uses, r, wes[i], rds[i])) return i + 1;
    return 0;
  endfunction

  task automatic clear_inputs();
    {id_rs, id_rt, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rs, id_uses_rt, id_is_branch, id_md_start, id_md_type} = '0;
    {id_hilo_read, branch_taken, ex_regwrite, ex_memload} = '0;
    {mem_regwrite, mem_memload, wb_regwrite} = '0;
  endtask

  // check all outputs against the model mid-cycle, then advance model and clock
  task automatic cycle();
    int  fa, fb, nb, ns;
    bit  ex_dep, mem_dep, lu, bh, mh, st;
    @(negedge clk);
    ex_dep  = source_of(id_uses_rs, id_rs) == 1 || source_of(id_uses_rt, id_rt) == 1;
    mem_dep = dep(id_uses_rs, id_rs, mem_regwrite, mem_rd) ||
              dep(id_uses_rt, id_rt, mem_regwrite, mem_rd);
    lu = ex_memload && ex_dep;
    bh = id_is_branch && (ex_dep || (mem_memload && mem_dep));
    mh = (m_busy_rem > 0) && (id_hilo_read || id_md_start);
    st = !reset && (lu || bh || mh);
    fa = reset ? 0 : source_of(id_uses_rs, id_rs);
    fb = reset ? 0 : source_of(id_uses_rt, id_rt);
    chk("fwd_a_sel", fwd_a_sel, fa);
    chk("fwd_b_sel", fwd_b_sel, fb);
    chk("pc_le", pc_le, int'(!reset && !st));
    chk("ifid_le", ifid_le, int'(!reset && !st));
    chk("idex_nop", idex_nop, int'(reset || st));
    chk("ifid_flush", ifid_flush, int'(!reset && branch_taken && !st));
    chk("md_busy", md_busy, int'(m_busy_rem > 0));
    chk("stall_cnt", stall_cnt, m_stall_cnt);
    if (reset) begin
      nb = 0; ns = 0;
    end else begin
      ns = (st && m_stall_cnt < CNT_MAX) ? m_stall_cnt + 1 : m_stall_cnt;
      if (m_busy_rem > 0)            nb = m_busy_rem - 1;
      else if (id_md_start && !st)   nb = id_md_type ? DIV_LAT : MULT_LAT;
      else                           nb = 0;
    end
    @(posedge clk);
    m_busy_rem  = nb;
    m_stall_cnt = ns;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    #1;
    cycle();
    cycle();
    reset = 1'b0;

    // forwarding priority
    id_uses_rs = 1; id_rs = 3; ex_rd = 3; ex_regwrite = 1;
    #3 chk("fwd_ex", fwd_a_sel, 1); chk("fwd_ex_nostall", pc_le, 1); cycle();
    ex_regwrite = 0; mem_rd = 3; mem_regwrite = 1;
    #3 chk("fwd_mem", fwd_a_sel, 2); cycle();
    mem_regwrite = 0; wb_rd = 3; wb_regwrite = 1;
    #3 chk("fwd_wb", fwd_a_sel, 3); cycle();
    ex_regwrite = 1;
    #3 chk("fwd_ex_over_wb", fwd_a_sel, 1); cycle();
    id_rs = 0; ex_rd = 0; wb_rd = 0;
    #3 chk("fwd_r0", fwd_a_sel, 0); cycle();

    // load-use
    clear_inputs();
    id_uses_rt = 1; id_rt = 5; ex_rd = 5; ex_regwrite = 1; ex_memload = 1;
    #3 chk("lu_pc_le", pc_le, 0); chk("lu_nop", idex_nop, 1); cycle();
    ex_regwrite = 0; ex_memload = 0; mem_rd = 5; mem_regwrite = 1; mem_memload = 1;
    #3 chk("lu_fwd_mem", fwd_b_sel, 2); chk("lu_go", pc_le, 1); chk("lu_cnt", stall_cnt, 1); cycle();

    // branch after ALU producer, then after load producer
    clear_inputs();
    id_is_branch = 1; id_uses_rs = 1; id_rs = 7; ex_rd = 7; ex_regwrite = 1;
    #3 chk("br_alu_stall", pc_le, 0); cycle();
    ex_regwrite = 0; mem_rd = 7; mem_regwrite = 1;
    #3 chk("br_alu_go", pc_le, 1); chk("br_alu_cnt", stall_cnt, 2); cycle();
    mem_regwrite = 0; ex_regwrite = 1; ex_memload = 1;
    cycle();
    ex_regwrite = 0; ex_memload = 0; mem_regwrite = 1; mem_memload = 1;
    #3 chk("br_lw_stall2", pc_le, 0); cycle();
    mem_regwrite = 0; mem_memload = 0; wb_rd = 7; wb_regwrite = 1;
    #3 chk("br_lw_go", pc_le, 1); chk("br_lw_cnt", stall_cnt, 4); cycle();

    // mult then mfhi
    clear_inputs();
    do_reset();
    id_md_start = 1;
    #3 chk("mult_accept", pc_le, 1); cycle();
    id_md_start = 0; id_hilo_read = 1;
    for (int i = 0; i < MULT_LAT; i++) begin
      #3 chk("mfhi_busy", md_busy, 1); chk("mfhi_stall", pc_le, 0); cycle();
    end
    #3 chk("mfhi_done", md_busy, 0); chk("mfhi_go", pc_le, 1); chk("mfhi_cnt", stall_cnt, 4); cycle();

    // div aborted by reset
    clear_inputs();
    id_md_start = 1; id_md_type = 1;
    cycle();
    clear_inputs();
    for (int i = 0; i < 6; i++) cycle();
    id_hilo_read = 1; reset = 1;
    #3 chk("rst_pc_le", pc_le, 0); chk("rst_fwd", fwd_a_sel, 0); cycle();
    reset = 0;
    #3 chk("rst_md_busy", md_busy, 0); chk("rst_cnt", stall_cnt, 0); chk("rst_mfhi_go", pc_le, 1); cycle();

    // taken-branch flush, suppressed by a stall
    clear_inputs();
    branch_taken = 1;
    #3 chk("flush", ifid_flush, 1); cycle();
    id_uses_rs = 1; id_rs = 9; ex_rd = 9; ex_regwrite = 1; ex_memload = 1;
    #3 chk("flush_stalled", ifid_flush, 0); cycle();

    // counter saturation
    for (int i = 0; i < CNT_MAX + 8; i++) cycle();
    #3 chk("cnt_sat", stall_cnt, CNT_MAX); cycle();

    // random traffic
    clear_inputs();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 59) == 0);
      id_rs        = 5'($urandom_range(0, 7));
      id_rt        = 5'($urandom_range(0, 7));
      ex_rd        = 5'($urandom_range(0, 7));
      mem_rd       = 5'($urandom_range(0, 7));
      wb_rd        = 5'($urandom_range(0, 7));
      id_uses_rs   = 1'($urandom);
      id_uses_rt   = 1'($urandom);
      id_is_branch = ($urandom_range(0, 3) == 0);
      id_md_start  = ($urandom_range(0, 4) == 0);
      id_md_type   = 1'($urandom);
      id_hilo_read = ($urandom_range(0, 3) == 0);
      branch_taken = 1'($urandom);
      ex_regwrite  = 1'($urandom);
      ex_memload   = 1'($urandom);
      mem_regwrite = 1'($urandom);
      mem_memload  = 1'($urandom);
      wb_regwrite  = 1'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
